// File: rtl/adder_128b.sv
// Registered 128-bit unsigned adder producing a 129-bit sum.
// Define ADDER_128B_PIPE_EN to split the carry chain at bit 64 into a two-stage pipeline.
module adder_128b (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in0,
    input  logic [127:0] in1,
    output logic [127:0] out0,
    output logic         out1,
    output logic         out_valid
);

`ifdef ADDER_128B_PIPE_EN

    logic [63:0] s1_lo;
    logic        s1_carry;
    logic [63:0] s1_a_hi;
    logic [63:0] s1_b_hi;
    logic        s1_valid;

    logic [64:0] lo_sum;
    logic [64:0] hi_sum;

    always_comb begin
        lo_sum = {1'b0, in0[63:0]} + {1'b0, in1[63:0]};
        hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {64'd0, s1_carry};
    end

    // Each stage's data registers load only when that stage holds a valid pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_lo    <= '0;
            s1_carry <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo    <= lo_sum[63:0];
                s1_carry <= lo_sum[64];
                s1_a_hi  <= in0[127:64];
                s1_b_hi  <= in1[127:64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0      <= '0;
            out1      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out0 <= {hi_sum[63:0], s1_lo};
                out1 <= hi_sum[64];
            end
        end
    end

`else

    logic [128:0] sum;

    always_comb begin
        sum = {1'b0, in0} + {1'b0, in1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0      <= '0;
            out1      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out0 <= sum[127:0];
                out1 <= sum[128];
            end
        end
    end

`endif

endmodule

// File: tb/tb_adder_128b.sv
// Self-checking bench for adder_128b: directed corner cases, random streaming,
// hold and mid-stream reset, scored against a latency-aware expected-result queue.
module tb_adder_128b;

`ifdef ADDER_128B_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in0;
    logic [127:0] in1;
    logic [127:0] out0;
    logic         out1;
    logic         out_valid;

    typedef struct {
        logic         v;
        logic [128:0] s;
    } exp_t;

    exp_t         sb[$];
    logic [128:0] held;
    int           tests;
    int           failures;

    adder_128b dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in0      (in0),
        .in1      (in1),
        .out0     (out0),
        .out1     (out1),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic fill_bubbles();
        exp_t b;
        b.v = 1'b0;
        b.s = '0;
        sb.delete();
        for (int i = 0; i < LAT - 1; i++) sb.push_back(b);
    endtask

    // Drive one cycle of inputs, advance one edge, then score the outputs.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [127:0] a, input logic [127:0] b);
        exp_t e;
        rst      = r;
        in_valid = v;
        in0      = a;
        in1      = b;
        e.v = v && !r;
        e.s = {1'b0, a} + {1'b0, b};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (r) begin
            fill_bubbles();
            held = '0;
            e.v  = 1'b0;
        end else if (e.v) begin
            held = e.s;
        end
        tests++;
        assert (out_valid === e.v) else begin
            failures++;
            $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, e.v);
        end
        tests++;
        assert ({out1, out0} === held) else begin
            failures++;
            $error("FAIL %s sum got %h want %h", tag, {out1, out0}, held);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] ones;
        logic [127:0] lo_ones;
        clk      = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in0      = '0;
        in1      = '0;
        held     = '0;
        tests    = 0;
        failures = 0;
        ones     = '1;
        lo_ones  = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        fill_bubbles();

        step("reset0", 1'b1, 1'b0, '0, '0);
        step("reset1", 1'b1, 1'b1, ones, ones);
        step("zero", 1'b0, 1'b1, '0, '0);
        step("fullcarry", 1'b0, 1'b1, ones, 128'd1);
        step("maxsum", 1'b0, 1'b1, ones, ones);
        step("midcarry", 1'b0, 1'b1, lo_ones, 128'd1);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b0, rnd128(), rnd128());

        for (int i = 0; i < 1000; i++) step("stream", 1'b0, 1'b1, rnd128(), rnd128());
        for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, rnd128(), rnd128());

        for (int i = 0; i < 6; i++) step("gapped", 1'b0, (i % 2) == 0, rnd128(), rnd128());

        for (int i = 0; i < 3; i++) step("preflush", 1'b0, 1'b1, rnd128(), rnd128());
        step("midreset", 1'b1, 1'b1, rnd128(), rnd128());
        for (int i = 0; i < 3; i++) step("postflush", 1'b0, 1'b0, rnd128(), rnd128());
        step("afterrst", 1'b0, 1'b1, lo_ones, ones);
        for (int i = 0; i < 3; i++) step("tail", 1'b0, 1'b0, '0, '0);

        step("rstfirst", 1'b1, 1'b0, '0, '0);
        step("firstop", 1'b0, 1'b1, ones, 128'd1);
        for (int i = 0; i < 3; i++) step("final", 1'b0, 1'b0, rnd128(), rnd128());

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/adder_128b.md
ADDER_128B -- requirements
Module: adder_128b

Interface
REQ-001 Parameters: none; operand width is fixed at 128 bits and result width at 129 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  high marks in0/in1 as a valid operand pair for this cycle.
REQ-005 in0  input  128  unsigned operand A.
REQ-006 in1  input  128  unsigned operand B.
REQ-007 out0  output  128  registered sum bits [127:0].
REQ-008 out1  output  1  registered carry-out, which is sum bit 128.
REQ-009 out_valid  output  1  high for exactly one cycle when out0/out1 carry a new result.

Function
REQ-010 The result SHALL satisfy {out1,out0} = in0 + in1 as an unsigned 129-bit sum, with no truncation, saturation or signed interpretation.
REQ-011 Latency SHALL be 1 cycle with the macro undefined: a pair sampled with in_valid=1 at edge N SHALL appear on out0/out1 with out_valid=1 after edge N.
REQ-012 Throughput SHALL be one operation per cycle, and back-to-back in_valid pulses SHALL produce back-to-back out_valid pulses in issue order.
REQ-013 When in_valid=0, out0/out1 SHALL hold their last value and out_valid SHALL be 0 on the following cycle.
REQ-014 Inputs SHALL be sampled only when in_valid=1; in0/in1 values present while in_valid=0 SHALL have no effect.
REQ-015 The operand pairs 0+0, all-ones+all-ones and all-ones+1 SHALL produce exact results with no special-casing.
REQ-016 The design SHALL contain no combinational path from any input to any output.

Reset
REQ-017 While rst=1 at a rising edge, out0 SHALL become 0, out1 SHALL become 0, out_valid SHALL become 0, and every internal pipeline register SHALL be cleared.
REQ-018 in_valid asserted in the same cycle as rst SHALL be ignored, because reset has priority.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight results, and no out_valid pulse SHALL be emitted for them after reset deasserts.
REQ-020 The first operation after reset SHALL be accepted in the first cycle with rst=0.

Configuration
REQ-021 Macro ADDER_128B_PIPE_EN SHALL select a two-stage pipeline.
REQ-022 With ADDER_128B_PIPE_EN defined, stage 1 SHALL register the lower 64-bit sum, the carry out of bit 63, the upper operand halves and valid.
REQ-023 With ADDER_128B_PIPE_EN defined, stage 2 SHALL add the upper halves plus the registered carry to form out0[127:64] and out1.
REQ-024 With ADDER_128B_PIPE_EN defined, latency SHALL be 2 cycles, throughput SHALL remain 1 per cycle, and results SHALL be identical to the unpipelined build.
REQ-025 Without ADDER_128B_PIPE_EN, the design SHALL be a single registered stage with latency 1, as in REQ-011.
REQ-026 Reset and hold behaviour (REQ-013, REQ-017 to REQ-020) SHALL apply to every stage in both builds.

Verification
REQ-027 Zero case: rst then in0=0, in1=0, in_valid=1 -> out0=0, out1=0, out_valid=1 after the configured latency.
REQ-028 Full-width carry: in0=all-ones (128 bits), in1=1 -> out0=0, out1=1.
REQ-029 Maximum sum: in0=in1=all-ones -> out0=FFFF...FFFE (128 bits), out1=1.
REQ-030 Mid-width carry: in0=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, in1=1 -> out0=0x0000_0000_0000_0001_0000_0000_0000_0000, out1=0; this checks the 64-bit stage boundary.
REQ-031 Streaming: 1000 consecutive random pairs with in_valid held high -> each out_valid result equals the 129-bit reference sum in order; then in_valid=0 -> outputs hold and out_valid=0.
REQ-032 Reset mid-stream: assert rst for 1 cycle with operations in flight -> no stale out_valid pulses, outputs read 0, and the next operation is correct.
